// File: rtl/mux_pkg.sv
// Shared definitions for the dual-lane order-restoring merge.
//   WIDTH_DEF / DEPTH_DEF : default lane width and per-lane FIFO depth
//   lane_t                : lane index (1 bit), LANE0 / LANE1 values
package mux_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef logic lane_t;

  localparam lane_t LANE0 = 1'b0;
  localparam lane_t LANE1 = 1'b1;

endpackage : mux_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read (no write-through).
//   clk, reset_L : clock, synchronous active-low reset (empties the FIFO)
//   push, din    : write request and data; accepted when not full or when
//                  a pop happens in the same cycle
//   pop          : read request; ignored when empty
//   dout         : current head word
//   full, empty  : status derived from the pointers
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a push into a full FIFO survives it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push && reset_L) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule : sync_fifo

// File: rtl/mux_interleave_2to1.sv
// Order-restoring 2:1 merge of two valid-qualified lanes. Words leave
// strictly alternating lane 0, lane 1, ... starting at lane 0; a per-lane
// FIFO absorbs skew between lanes.
//   clk, reset_L           : clock, synchronous active-low reset
//   data_in0, valid_in0    : lane 0 word and qualifier
//   data_in1, valid_in1    : lane 1 word and qualifier
//   data_out, valid_out    : merged word (registered), holds when idle
//   overflow               : sticky, a word was dropped on a full lane
module mux_interleave_2to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             overflow
);

  logic [WIDTH-1:0] dout0, dout1;
  logic             full0, full1, empty0, empty1;
  logic             pop0, pop1, drop0, drop1;

  lane_t            sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (valid_in0),
    .din     (data_in0),
    .pop     (pop0),
    .dout    (dout0),
    .full    (full0),
    .empty   (empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (valid_in1),
    .din     (data_in1),
    .pop     (pop1),
    .dout    (dout1),
    .full    (full1),
    .empty   (empty1)
  );

  // Only the expected lane may pop; the other lane waits even if it holds data.
  assign pop0 = (sel_q == LANE0) && !empty0;
  assign pop1 = (sel_q == LANE1) && !empty1;

  // A push is lost only when the lane is full and not draining this cycle.
  assign drop0 = valid_in0 && full0 && !pop0;
  assign drop1 = valid_in1 && full1 && !pop1;

  // Output steering and expected-lane advance
  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q || drop0 || drop1;
    if (pop0) begin
      data_d  = dout0;
      valid_d = 1'b1;
      sel_d   = LANE1;
    end else if (pop1) begin
      data_d  = dout1;
      valid_d = 1'b1;
      sel_d   = LANE0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sel_q   <= LANE0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overflow  = ovf_q;

endmodule : mux_interleave_2to1

// File: tb/tb_mux_interleave_2to1.sv
// Self-checking bench for mux_interleave_2to1: directed scenarios with
// literal expected output sequences, then randomized traffic against a
// queue-based reference model.
module tb_mux_interleave_2to1;
  import mux_pkg::*;

  localparam int unsigned W = WIDTH_DEF;
  localparam int unsigned D = DEPTH_DEF;

  logic         clk = 1'b0;
  logic         reset_L;
  logic [W-1:0] data_in0, data_in1, data_out;
  logic         valid_in0, valid_in1, valid_out, overflow;

  always #5 clk = ~clk;

  mux_interleave_2to1 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: one queue per lane plus expected-lane pointer
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_sel;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;

  logic [W-1:0] emitted[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference behaviour: pop the expected lane first,
  // then pushes, so a full lane that just popped still has room.
  task automatic model_edge(input logic rst_l, input logic v0, input logic [W-1:0] d0,
                            input logic v1, input logic [W-1:0] d1);
    if (!rst_l) begin
      q0.delete();
      q1.delete();
      m_sel   = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (m_sel == 0 && q0.size() > 0) begin
      m_data  = q0.pop_front();
      m_valid = 1'b1;
      m_sel   = 1;
    end else if (m_sel == 1 && q1.size() > 0) begin
      m_data  = q1.pop_front();
      m_valid = 1'b1;
      m_sel   = 0;
    end
    if (v0) begin
      if (q0.size() < int'(D)) q0.push_back(d0);
      else m_ovf = 1'b1;
    end
    if (v1) begin
      if (q1.size() < int'(D)) q1.push_back(d1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic rst_l, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1);
    reset_L   = rst_l;
    valid_in0 = v0;
    data_in0  = d0;
    valid_in1 = v1;
    data_in1  = d1;
    @(posedge clk);
    model_edge(rst_l, v0, d0, v1, d1);
    #1;
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("data_out",  32'(data_out),  32'(m_data));
    check("overflow",  32'(overflow),  32'(m_ovf));
    if (valid_out === 1'b1) emitted.push_back(data_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // Compare the captured output stream with the literal expectation in exp_q.
  task automatic expect_seq(input string tag);
    check({tag, "_len"}, 32'(emitted.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < emitted.size(); i++)
      check({tag, "_word"}, 32'(emitted[i]), 32'(exp_q[i]));
    emitted.delete();
  endtask

  initial begin
    reset_L   = 1'b0;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    data_in0  = '0;
    data_in1  = '0;

    // Reset held with both lanes valid: nothing may be captured or emitted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB);
    check("rst_data",  32'(data_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    idle(3);
    exp_q = {};
    expect_seq("reset");

    // Alternating stream
    step(1'b1, 1'b1, 8'h11, 1'b0, '0);
    step(1'b1, 1'b0, '0,    1'b1, 8'h22);
    step(1'b1, 1'b1, 8'h33, 1'b0, '0);
    idle(3);
    exp_q = '{8'h11, 8'h22, 8'h33};
    expect_seq("alt");

    // Re-align sel to lane 0 before each new scenario
    step(1'b0, 1'b0, '0, 1'b0, '0);

    // Skew: lane 1 arrives early, nothing leaves until lane 0 catches up
    step(1'b1, 1'b0, '0, 1'b1, 8'hA1);
    step(1'b1, 1'b0, '0, 1'b1, 8'hA2);
    idle(2);
    step(1'b1, 1'b1, 8'hB1, 1'b0, '0);
    check("skew_quiet", 32'(emitted.size()), 32'h0);
    step(1'b1, 1'b1, 8'hB2, 1'b0, '0);
    idle(4);
    exp_q = '{8'hB1, 8'hA1, 8'hB2, 8'hA2};
    expect_seq("skew");

    step(1'b0, 1'b0, '0, 1'b0, '0);

    // Simultaneous arrival
    step(1'b1, 1'b1, 8'h01, 1'b1, 8'h02);
    idle(3);
    exp_q = '{8'h01, 8'h02};
    expect_seq("simul");

    step(1'b0, 1'b0, '0, 1'b0, '0);

    // Overflow: fifth lane 1 word dropped, flag sticky
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1, 8'(8'hC0 + i));
    check("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, '0);
    idle(6);
    check("ovf_sticky", 32'(overflow), 32'h1);
    exp_q = '{8'hD0, 8'hC0, 8'hD1, 8'hC1, 8'hD2, 8'hC2, 8'hD3, 8'hC3};
    expect_seq("ovf");

    // Reset mid-stream discards buffered words
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 8'h55, 1'b1, 8'h66);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    step(1'b1, 1'b1, 8'h77, 1'b0, '0);
    idle(3);
    exp_q = '{8'h77};
    expect_seq("midrst");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic r, v0, v1;
      r  = ($urandom_range(0, 299) != 0);
      v0 = ($urandom_range(0, 99) < 55);
      v1 = ($urandom_range(0, 99) < 55);
      step(r, v0, 8'($urandom), v1, 8'($urandom));
    end
    emitted.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_interleave_2to1

// File: doc/mux_interleave_2to1.md
# mux_interleave_2to1

Order-restoring 2:1 merge of two valid-qualified byte lanes into one stream; the inverse of the lane-alternating 1:2 demux on the far side of the link. Words are emitted strictly alternating lane 0, lane 1, lane 0, … starting from lane 0 after reset. A per-lane FIFO absorbs arrival skew between lanes. Sits at the receive end of the dual-lane path, ahead of the single-lane consumer.

## Interface
- WIDTH, 8, data width of every lane.
- DEPTH, 4, entries per lane FIFO; power of two, ≥ 2.
- clk  input  1  clock; all logic on posedge.
- reset_L  input  1  reset; synchronous, active-low.
- data_in0  input  WIDTH  lane 0 word.
- valid_in0  input  1  lane 0 word present this cycle.
- data_in1  input  WIDTH  lane 1 word.
- valid_in1  input  1  lane 1 word present this cycle.
- data_out  output  WIDTH  merged word; registered.
- valid_out  output  1  data_out valid this cycle; registered.
- overflow  output  1  sticky: a word arrived on a full lane and was dropped.

## Operation
- Reset (reset_L = 0 at posedge): both FIFOs emptied, expected-lane pointer `sel` = 0, data_out = 0, valid_out = 0, overflow = 0.
- Push: lane i word pushed into FIFO i on any posedge where valid_in_i = 1. Both lanes may push in the same cycle.
- Pop: each cycle, if FIFO[sel] non-empty, pop its head, register it to data_out, set valid_out = 1, toggle sel. Otherwise valid_out = 0, sel unchanged, data_out holds last emitted word.
- At most one pop per cycle. Non-selected lane never pops, even if it holds data and the selected lane is empty (order preservation beats throughput).
- Full: a push to a full FIFO is accepted if that FIFO pops in the same cycle; otherwise the word is dropped, FIFO contents unchanged, overflow set to 1 until reset.
- FIFO read/write pointers are log2(DEPTH)+1 bits; wrap modulo 2·DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
- Reset mid-operation: buffered words discarded; no output of stale data after reset is released.

## Timing
- Latency: word on valid_in_sel into empty FIFO[sel] at edge N → valid_out = 1 with that word after edge N+1 (one cycle; FIFO has no write-through).
- Sustained throughput: 1 word/cycle when lanes alternate arrivals, matching the demux output rate.
- sel toggles on the same edge that registers valid_out = 1.
- overflow rises on the edge the dropped push would have occurred.

## Structure
- Shared package `mux_pkg`: WIDTH_DEF = 8, DEPTH_DEF = 4, lane index type (1 bit), LANE0/LANE1 constants.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports clk, reset_L, push, din, pop, dout, full, empty), instantiated once per lane; top holds sel, pop steering, output register and overflow flag.

## Test plan
- Reset: hold reset_L = 0 with valid_in0 = valid_in1 = 1 for 3 cycles → data_out = 0, valid_out = 0, overflow = 0 throughout; no word emitted after release.
- Alternating stream: lane0 0x11 at cycle 1, lane1 0x22 at cycle 2, lane0 0x33 at cycle 3 → valid_out high cycles 2,3,4 with 0x11, 0x22, 0x33.
- Skew: lane1 sends 0xA1, 0xA2 at cycles 1–2, lane0 sends 0xB1, 0xB2 at cycles 5–6 → no output until cycle 6; then 0xB1, 0xA1, 0xB2, 0xA2 on consecutive cycles.
- Simultaneous: both lanes valid at cycle 1 (0x01 lane0, 0x02 lane1) → 0x01 at cycle 2, 0x02 at cycle 3.
- Overflow: 5 lane1 words (0xC0–0xC4) with lane0 idle → first 4 buffered, 0xC4 dropped, overflow = 1 and sticky; then lane0 sends 0xD0–0xD3 → output 0xD0, 0xC0, 0xD1, 0xC1, 0xD2, 0xC2, 0xD3, 0xC3.
- Reset mid-stream: buffer 0x55 in lane0, 0x66 in lane1, pulse reset_L low one cycle → FIFOs empty, sel = 0; next lane0 word 0x77 emitted first with no 0x55/0x66.
